// File: rtl/i2c_target.sv
// I2C target with a small auto-incrementing byte register file; stands in for the G-sensor.
// Optional glitch filter on the synchronized lines: define I2C_TGT_FILTER_EN.
`timescale 1ns/1ps

module i2c_target #(
  parameter logic [6:0] TGT_ADDR = 7'h1D,
  parameter int         NUM_REGS = 16,
  parameter int         PTR_W    = 4
`ifdef I2C_TGT_FILTER_EN
  , parameter int       FILT_LEN = 4
`endif
) (
  input  logic             CLK_50,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             addressed
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  logic             r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic             r_scl_d, r_sda_d;
  logic             w_scl, w_sda;
  logic             w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]       w_byte;

  state_t           r_state;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_rw, r_ack_drv, r_load;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_regs [NUM_REGS];
  logic             r_sda_oe, r_wr_strobe, r_addressed;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge CLK_50 or negedge rst) begin
    if (!rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TGT_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN + 1);
  logic [1:0] w_sync, w_filt;
  assign w_sync = {r_sda_s2, r_scl_s2};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic             r_filt;
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge CLK_50 or negedge rst) begin
        if (!rst) begin
          r_filt <= 1'b1;
          r_cnt  <= '0;
        end else if (w_sync[gi] == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
          r_filt <= w_sync[gi];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_filt[gi] = r_filt;
    end
  endgenerate

  assign w_scl = w_filt[0];
  assign w_sda = w_filt[1];
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge CLK_50 or negedge rst) begin
    if (!rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};

  always_ff @(posedge CLK_50 or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_load      <= 1'b0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_addressed <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state     <= S_IDLE;
        r_sda_oe    <= 1'b0;
        r_addressed <= 1'b0;
      end else if (w_start) begin
        r_state     <= S_ADDR;
        r_bit_cnt   <= '0;
        r_ack_drv   <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_addressed <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              r_ack_drv <= 1'b0;
              if (w_byte[7:1] == TGT_ADDR) begin
                r_rw    <= w_byte[0];
                r_state <= S_ADDR_ACK;
              end else begin
                r_state <= S_IGNORE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_PTR, S_WDATA: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              r_ack_drv <= 1'b0;
              if (r_state == S_PTR) begin
                r_ptr   <= w_byte[PTR_W-1:0];
                r_state <= S_PTR_ACK;
              end else begin
                r_regs[r_ptr] <= w_byte;
                r_wr_strobe   <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte;
                r_ptr         <= r_ptr + 1'b1;
                r_state       <= S_WDATA_ACK;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          // First SCL fall drives ACK low, second fall releases it and moves on.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (w_scl_fall) begin
            if (!r_ack_drv) begin
              r_ack_drv <= 1'b1;
              r_sda_oe  <= 1'b1;
              if (r_state == S_ADDR_ACK) r_addressed <= 1'b1;
            end else begin
              r_ack_drv <= 1'b0;
              r_bit_cnt <= '0;
              r_sda_oe  <= 1'b0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                r_state  <= S_RDATA;
                r_load   <= 1'b0;
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_shift  <= {r_regs[r_ptr][6:0], 1'b0};
              end else if (r_state == S_ADDR_ACK) begin
                r_state <= S_PTR;
              end else begin
                r_state <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_load) begin
                r_load   <= 1'b0;
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_shift  <= {r_regs[r_ptr][6:0], 1'b0};
              end else if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= S_RDATA_ACK;
              end else begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: if (w_scl_rise) begin
            if (!w_sda) begin
              r_ptr     <= r_ptr + 1'b1;
              r_load    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= S_RDATA;
            end else begin
              r_state <= S_IGNORE;
            end
          end
          S_IDLE, S_IGNORE: r_sda_oe <= 1'b0;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign addressed  = r_addressed;
  assign host_rdata = r_regs[host_addr];

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged initiator, transaction-level model, per-cycle monitor.
`timescale 1ns/1ps

module tb_i2c_target;
  localparam int H = 16;

  logic       CLK_50 = 1'b0;
  logic       rst = 1'b0;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       scl_in, sda_in, sda_oe;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] host_rdata;
  logic       wr_strobe, addressed;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  always #10 CLK_50 = ~CLK_50;

  i2c_target dut (
    .CLK_50(CLK_50), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .addressed(addressed)
  );

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

  int         total = 0, bad = 0;
  logic [7:0] mdl_regs [16];
  logic [7:0] cyc_regs [16];
  logic [3:0] mdl_ptr = 4'd0;
  wr_t        exp_q[$], seen_q[$];
  logic [7:0] tx_q[$], rd_q[$];
  bit         quiet = 1'b0;
  wr_t        e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK_50) begin
    if (rst) begin
      if (wr_strobe) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.a));
          check("wr_data", 32'(wr_data), 32'(e.d));
          cyc_regs[e.a] = e.d;
        end
        seen_q.push_back({wr_addr, wr_data});
      end
      check("host_rdata", 32'(host_rdata), 32'(cyc_regs[host_addr]));
      if (quiet) begin
        check("quiet_sda_oe", 32'(sda_oe), 32'd0);
        check("quiet_addressed", 32'(addressed), 32'd0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK_50);
      #1 host_addr = host_addr + 4'd1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic wc(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  task automatic bit_io(input logic b, output logic s);
    m_sda = b;   wc(H);
    m_scl = 1'b1; wc(H/2);
    s = sda_in;  wc(H/2);
    m_scl = 1'b0; wc(4);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wc(H);
    m_scl = 1'b1; wc(H);
    m_sda = 1'b0; wc(H);
    m_scl = 1'b0; wc(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wc(H);
    m_scl = 1'b1; wc(H);
    m_sda = 1'b1; wc(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    bit_io(nack, s);
  endtask

  // First byte of tx_q is the register pointer, the rest are data bytes.
  task automatic do_write(input logic [6:0] a, input bit stop, input string tag);
    logic ack;
    bit   match;
    match = (a == 7'h1D);
    i2c_start();
    write_byte({a, 1'b0}, ack);
    check({tag, "_addr_ack"}, 32'(ack), match ? 32'd0 : 32'd1);
    check({tag, "_addressed"}, 32'(addressed), 32'(match));
    foreach (tx_q[i]) begin
      if (match) begin
        if (i == 0) mdl_ptr = tx_q[i][3:0];
        else begin
          exp_q.push_back({mdl_ptr, tx_q[i]});
          mdl_regs[mdl_ptr] = tx_q[i];
          mdl_ptr = mdl_ptr + 4'd1;
        end
      end
      write_byte(tx_q[i], ack);
      check({tag, "_byte_ack"}, 32'(ack), match ? 32'd0 : 32'd1);
    end
    if (stop) begin
      i2c_stop(); wc(8);
      check({tag, "_addressed_after_stop"}, 32'(addressed), 32'd0);
    end
  endtask

  task automatic do_read(input int n, input string tag);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    write_byte({7'h1D, 1'b1}, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      check({tag, "_data"}, 32'(b), 32'(mdl_regs[mdl_ptr]));
      rd_q.push_back(b);
      if (i != n - 1) mdl_ptr = mdl_ptr + 4'd1;
    end
    i2c_stop(); wc(8);
    check({tag, "_addressed_after_stop"}, 32'(addressed), 32'd0);
  endtask

  initial begin
    logic ack, s;
    for (int i = 0; i < 16; i++) begin
      mdl_regs[i] = 8'h00;
      cyc_regs[i] = 8'h00;
    end

    wc(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_addressed", 32'(addressed), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    rst = 1'b1;
    wc(10);

    // Single write
    tx_q = '{8'h05, 8'hA7};
    do_write(7'h1D, 1'b1, "wr");
    check("wr_strobe_count", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() >= 1) begin
      check("wr_lit_addr", 32'(seen_q[0].a), 32'd5);
      check("wr_lit_data", 32'(seen_q[0].d), 32'hA7);
    end

    // Preload then pointer write + repeated START read
    tx_q = '{8'h02, 8'h11, 8'h22};
    do_write(7'h1D, 1'b1, "preload");
    tx_q = '{8'h02};
    do_write(7'h1D, 1'b0, "rdptr");
    rd_q.delete();
    do_read(2, "rd");
    if (rd_q.size() == 2) begin
      check("rd_lit0", 32'(rd_q[0]), 32'h11);
      check("rd_lit1", 32'(rd_q[1]), 32'h22);
    end

    // Pointer wrap on write and on read
    tx_q = '{8'hFF, 8'hAA, 8'hBB};
    do_write(7'h1D, 1'b1, "wrap");
    if (seen_q.size() >= 2) begin
      check("wrap_lit_addr_a", 32'(seen_q[seen_q.size()-2].a), 32'd15);
      check("wrap_lit_addr_b", 32'(seen_q[seen_q.size()-1].a), 32'd0);
    end
    tx_q = '{8'h0F};
    do_write(7'h1D, 1'b0, "wrapptr");
    rd_q.delete();
    do_read(2, "wraprd");
    if (rd_q.size() == 2) begin
      check("wrap_lit_rd0", 32'(rd_q[0]), 32'hAA);
      check("wrap_lit_rd1", 32'(rd_q[1]), 32'hBB);
    end

    // Wrong address: nobody answers, nothing written
    quiet = 1'b1;
    tx_q = '{8'h55};
    do_write(7'h20, 1'b1, "wrongaddr");
    quiet = 1'b0;

    // STOP after 4 data bits discards the byte
    i2c_start();
    write_byte(8'h3A, ack);
    check("mid_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h07, ack);
    check("mid_ptr_ack", 32'(ack), 32'd0);
    mdl_ptr = 4'd7;
    bit_io(1'b1, s); bit_io(1'b0, s); bit_io(1'b1, s); bit_io(1'b1, s);
    i2c_stop(); wc(8);
    check("mid_addressed", 32'(addressed), 32'd0);
    check("mid_sda_oe", 32'(sda_oe), 32'd0);
    tx_q = '{8'h09, 8'h5C};
    do_write(7'h1D, 1'b1, "after_mid");

    // Short SDA low glitch while SCL high, after being addressed
    i2c_start();
    write_byte(8'h3A, ack);
    check("glitch_addr_ack", 32'(ack), 32'd0);
    m_sda = 1'b1; wc(H);
    m_scl = 1'b1; wc(4);
    m_sda = 1'b0; wc(2);
    m_sda = 1'b1; wc(12);
`ifdef I2C_TGT_FILTER_EN
    check("glitch_addressed", 32'(addressed), 32'd1);
`else
    check("glitch_addressed", 32'(addressed), 32'd0);
`endif
    m_scl = 1'b0; wc(4);
    i2c_stop(); wc(8);
    check("glitch_addressed_after_stop", 32'(addressed), 32'd0);

    wc(20);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
